// File: rtl/mdu_ctrl.sv
// EX-side sequencer for the shared iterative multiply/divide unit (RV32M).
// Resolves divide-by-zero, signed overflow and x0 destinations locally; handles flush and timeout aborts.
module mdu_ctrl #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic [4:0]      req_waddr,
  input  logic            flush,
  output logic            stall_req,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_we,
  output logic [4:0]      out_waddr,
  output logic [XLEN-1:0] out_wdata,
  output logic            mdu_start,
  output logic            mdu_kill,
  output logic [2:0]      mdu_op,
  output logic [XLEN-1:0] mdu_a,
  output logic [XLEN-1:0] mdu_b,
  input  logic            mdu_done,
  input  logic [XLEN-1:0] mdu_result,
  output logic            timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  localparam logic [2:0]       OP_DIV   = 3'd4;
  localparam logic [2:0]       OP_DIVU  = 3'd5;
  localparam logic [2:0]       OP_REM   = 3'd6;
  localparam logic [2:0]       OP_REMU  = 3'd7;
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  ZERO     = {XLEN{1'b0}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [4:0]        waddr_q, waddr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic              out_we_q, out_we_d;
  logic              start_q, start_d;
  logic              kill_s;
  logic              tmo_s;
  logic              is_div_s;
  logic              is_rem_s;
  logic              b_zero_s;
  logic              ovf_s;

  // Operand classification for the locally resolved cases.
  always_comb begin
    is_div_s = (req_op == OP_DIV) || (req_op == OP_DIVU);
    is_rem_s = (req_op == OP_REM) || (req_op == OP_REMU);
    b_zero_s = (req_b == ZERO);
    ovf_s    = (req_a == MIN_NEG) && (req_b == ALL_ONES);
  end

  // Next-state, datapath latching and abort pulses; flush overrides everything.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    kill_s  = 1'b0;
    tmo_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && !flush) begin
          waddr_d = req_waddr;
          if (req_waddr == 5'd0) begin
            state_d = S_HOLD;
            we_d    = 1'b0;
            wdata_d = ZERO;
          end else if (is_div_s && b_zero_s) begin
            state_d = S_HOLD;
            we_d    = 1'b1;
            wdata_d = ALL_ONES;
          end else if (is_rem_s && b_zero_s) begin
            state_d = S_HOLD;
            we_d    = 1'b1;
            wdata_d = req_a;
          end else if ((req_op == OP_DIV) && ovf_s) begin
            state_d = S_HOLD;
            we_d    = 1'b1;
            wdata_d = MIN_NEG;
          end else if ((req_op == OP_REM) && ovf_s) begin
            state_d = S_HOLD;
            we_d    = 1'b1;
            wdata_d = ZERO;
          end else begin
            state_d = S_ISSUE;
            op_d    = req_op;
            a_d     = req_a;
            b_d     = req_b;
            we_d    = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (flush) begin
          state_d = S_IDLE;
          kill_s  = 1'b1;
        end else begin
          state_d = S_WAIT;
          cnt_d   = {CNT_W{1'b0}};
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_d = S_IDLE;
          kill_s  = 1'b1;
        end else if (mdu_done) begin
          state_d = S_HOLD;
          wdata_d = mdu_result;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          kill_s  = 1'b1;
          tmo_s   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_HOLD: begin
        if (flush || out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    out_valid_d = (state_d == S_HOLD);
    out_we_d    = (state_d == S_HOLD) && we_d;
    start_d     = (state_d == S_ISSUE);
  end

  // State and datapath registers; reset clears everything with no abort pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= 3'd0;
      a_q         <= ZERO;
      b_q         <= ZERO;
      waddr_q     <= 5'd0;
      wdata_q     <= ZERO;
      we_q        <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      out_valid_q <= 1'b0;
      out_we_q    <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_we_q    <= out_we_d;
      start_q     <= start_d;
    end
  end

  // Pipeline hold is combinational so EX releases in the same cycle the result is accepted.
  always_comb begin
    stall_req = !rst && req_valid && !((state_q == S_HOLD) && out_ready) && !flush;
  end

  assign out_valid   = out_valid_q;
  assign out_we      = out_we_q;
  assign out_waddr   = waddr_q;
  assign out_wdata   = wdata_q;
  assign mdu_start   = start_q;
  assign mdu_kill    = kill_s;
  assign timeout_err = tmo_s;
  assign mdu_op      = op_q;
  assign mdu_a       = a_q;
  assign mdu_b       = b_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl: MDU path, local fast paths, flush, timeout, hold and reset.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_waddr;
  logic        flush;
  logic        stall_req;
  logic        out_valid;
  logic        out_ready;
  logic        out_we;
  logic [4:0]  out_waddr;
  logic [31:0] out_wdata;
  logic        mdu_start;
  logic        mdu_kill;
  logic [2:0]  mdu_op;
  logic [31:0] mdu_a;
  logic [31:0] mdu_b;
  logic        mdu_done;
  logic [31:0] mdu_result;
  logic        timeout_err;

  int passed = 0;
  int total  = 0;
  int sc     = 0;

  mdu_ctrl #(.XLEN(32), .TIMEOUT(64), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_a(req_a),
    .req_b(req_b), .req_waddr(req_waddr), .flush(flush), .stall_req(stall_req),
    .out_valid(out_valid), .out_ready(out_ready), .out_we(out_we), .out_waddr(out_waddr),
    .out_wdata(out_wdata), .mdu_start(mdu_start), .mdu_kill(mdu_kill), .mdu_op(mdu_op),
    .mdu_a(mdu_a), .mdu_b(mdu_b), .mdu_done(mdu_done), .mdu_result(mdu_result),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] wa);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_waddr = wa;
    #1;
  endtask

  task automatic fast(input string tag, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] wa, input logic [31:0] exp_wdata,
                      input logic exp_we, input logic check_data);
    req(op, a, b, wa);
    chk({tag, "_stall_idle"}, {31'd0, stall_req}, 32'd1);
    tick();
    chk({tag, "_no_start"}, {31'd0, mdu_start}, 32'd0);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_we"}, {31'd0, out_we}, {31'd0, exp_we});
    chk({tag, "_stall_hold"}, {31'd0, stall_req}, 32'd0);
    if (check_data) begin
      chk({tag, "_wdata"}, out_wdata, exp_wdata);
      chk({tag, "_waddr"}, {27'd0, out_waddr}, {27'd0, wa});
    end
    req_valid = 1'b0;
    tick();
    chk({tag, "_idle"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_op     = 3'd0;
    req_a      = 32'd0;
    req_b      = 32'd0;
    req_waddr  = 5'd0;
    flush      = 1'b0;
    out_ready  = 1'b0;
    mdu_done   = 1'b0;
    mdu_result = 32'd0;
    tick();
    tick();
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_start", {31'd0, mdu_start}, 32'd0);
    chk("rst_kill", {31'd0, mdu_kill}, 32'd0);
    chk("rst_tmo", {31'd0, timeout_err}, 32'd0);
    chk("rst_a", mdu_a, 32'd0);
    chk("rst_wdata", out_wdata, 32'd0);
    rst = 1'b0;

    // MUL 7*6 with done on the fourth WAIT cycle
    out_ready = 1'b1;
    req(3'd0, 32'd7, 32'd6, 5'd5);
    sc = int'(stall_req);
    chk("mul_idle_start", {31'd0, mdu_start}, 32'd0);
    tick();
    sc += int'(stall_req);
    chk("mul_start", {31'd0, mdu_start}, 32'd1);
    chk("mul_a", mdu_a, 32'd7);
    chk("mul_b", mdu_b, 32'd6);
    chk("mul_op", {29'd0, mdu_op}, 32'd0);
    tick();
    sc += int'(stall_req);
    chk("mul_start_pulse", {31'd0, mdu_start}, 32'd0);
    tick();
    sc += int'(stall_req);
    tick();
    sc += int'(stall_req);
    tick();
    mdu_done   = 1'b1;
    mdu_result = 32'd42;
    #1;
    sc += int'(stall_req);
    chk("mul_done_kill", {31'd0, mdu_kill}, 32'd0);
    tick();
    mdu_done = 1'b0;
    chk("mul_valid", {31'd0, out_valid}, 32'd1);
    chk("mul_wdata", out_wdata, 32'd42);
    chk("mul_waddr", {27'd0, out_waddr}, 32'd5);
    chk("mul_we", {31'd0, out_we}, 32'd1);
    chk("mul_hold_stall", {31'd0, stall_req}, 32'd0);
    chk("mul_stall_cycles", sc, 32'd6);
    req_valid = 1'b0;
    tick();
    chk("mul_idle", {31'd0, out_valid}, 32'd0);

    // Locally resolved cases
    fast("divu0", 3'd5, 32'd10, 32'd0, 5'd3, 32'hFFFF_FFFF, 1'b1, 1'b1);
    fast("rem0", 3'd6, 32'd9, 32'd0, 5'd4, 32'd9, 1'b1, 1'b1);
    fast("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000, 1'b1, 1'b1);
    fast("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'd0, 1'b1, 1'b1);
    fast("x0", 3'd0, 32'd3, 32'd4, 5'd0, 32'd0, 1'b0, 1'b0);

    // DIVU with overflow-looking operands uses the MDU; flush in WAIT
    req(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
    tick();
    chk("flush_start", {31'd0, mdu_start}, 32'd1);
    tick();
    tick();
    flush = 1'b1;
    #1;
    chk("flush_kill", {31'd0, mdu_kill}, 32'd1);
    chk("flush_stall", {31'd0, stall_req}, 32'd0);
    tick();
    flush     = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("flush_kill_pulse", {31'd0, mdu_kill}, 32'd0);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    mdu_done   = 1'b1;
    mdu_result = 32'd123;
    tick();
    mdu_done = 1'b0;
    chk("late_done_valid", {31'd0, out_valid}, 32'd0);
    chk("late_done_start", {31'd0, mdu_start}, 32'd0);
    tick();
    chk("late_done_idle", {31'd0, out_valid}, 32'd0);

    // Timeout: no done for 64 WAIT cycles
    req(3'd0, 32'd1, 32'd2, 5'd9);
    tick();
    tick();
    for (int i = 2; i <= 64; i++) begin
      tick();
      if (i == 63) begin
        chk("tmo_early", {31'd0, timeout_err}, 32'd0);
        chk("tmo_early_kill", {31'd0, mdu_kill}, 32'd0);
      end
    end
    chk("tmo_err", {31'd0, timeout_err}, 32'd1);
    chk("tmo_kill", {31'd0, mdu_kill}, 32'd1);
    chk("tmo_stall_wait", {31'd0, stall_req}, 32'd1);
    req_valid = 1'b0;
    tick();
    chk("tmo_err_pulse", {31'd0, timeout_err}, 32'd0);
    chk("tmo_kill_pulse", {31'd0, mdu_kill}, 32'd0);
    chk("tmo_valid", {31'd0, out_valid}, 32'd0);
    chk("tmo_stall_drop", {31'd0, stall_req}, 32'd0);

    // Done arriving on the timeout cycle wins
    req(3'd1, 32'd11, 32'd12, 5'd12);
    tick();
    tick();
    for (int i = 2; i <= 64; i++) begin
      tick();
    end
    mdu_done   = 1'b1;
    mdu_result = 32'd99;
    #1;
    chk("race_kill", {31'd0, mdu_kill}, 32'd0);
    chk("race_tmo", {31'd0, timeout_err}, 32'd0);
    tick();
    mdu_done = 1'b0;
    chk("race_valid", {31'd0, out_valid}, 32'd1);
    chk("race_wdata", out_wdata, 32'd99);
    req_valid = 1'b0;
    tick();

    // Downstream stalls HOLD for three cycles
    out_ready = 1'b0;
    req(3'd0, 32'd5, 32'd5, 5'd10);
    tick();
    tick();
    mdu_done   = 1'b1;
    mdu_result = 32'd25;
    tick();
    mdu_done = 1'b0;
    chk("hold0_valid", {31'd0, out_valid}, 32'd1);
    chk("hold0_stall", {31'd0, stall_req}, 32'd1);
    tick();
    chk("hold1_wdata", out_wdata, 32'd25);
    chk("hold1_waddr", {27'd0, out_waddr}, 32'd10);
    tick();
    chk("hold2_valid", {31'd0, out_valid}, 32'd1);
    chk("hold2_wdata", out_wdata, 32'd25);
    chk("hold2_stall", {31'd0, stall_req}, 32'd1);
    out_ready = 1'b1;
    #1;
    chk("hold_release", {31'd0, stall_req}, 32'd0);
    req_valid = 1'b0;
    tick();
    chk("hold_idle", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset in the middle of WAIT
    req(3'd3, 32'h0000_1234, 32'd2, 5'd11);
    tick();
    tick();
    tick();
    chk("prerst_op", {29'd0, mdu_op}, 32'd3);
    rst = 1'b1;
    #1;
    chk("midrst_stall", {31'd0, stall_req}, 32'd0);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_kill", {31'd0, mdu_kill}, 32'd0);
    chk("midrst_start", {31'd0, mdu_start}, 32'd0);
    chk("midrst_a", mdu_a, 32'd0);
    chk("midrst_op", {29'd0, mdu_op}, 32'd0);
    chk("midrst_wdata", out_wdata, 32'd0);
    rst       = 1'b0;
    req_valid = 1'b0;
    tick();
    chk("postrst_valid", {31'd0, out_valid}, 32'd0);
    chk("postrst_start", {31'd0, mdu_start}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
